mem_port_arbiter: RTL and testbench

Owns the single port of the instruction/data RAM and shares it between the boot loader, the CPU instruction-fetch unit and the CPU load/store unit. After reset it gives the port exclusively to the boot loader and holds the CPU stalled. Once the loader signals completion, it releases the CPU and arbitrates fetch and data requests cycle by cycle, with a starvation guard for fetch. It sits between the boot loader / CPU core and the synchronous-read RAM macro.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter_fetch_starve_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter, boot loader and RAM wrapper.
package mem_port_arbiter_pkg;

   localparam int RAM_ADDR_W = 16;
   localparam int RAM_DATA_W = 32;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2
   } arb_state_t;

   // Saturating 4-bit increment: never passes lim.
   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : v + 4'd1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side request bus: instruction fetch and load/store handshakes.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   // CPU core side
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
      input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata
   );

   // Arbiter side
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
      output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata
   );

endinterface

// File: rtl/mem_port_arbiter_fetch_starve_counter.sv
// Counts consecutive denied fetch cycles and forces one fetch win once the
// count reaches MAX_WAIT. Only counts while the arbiter is in RUN.
module fetch_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic run,
   input  logic if_req,
   input  logic if_gnt,
   output logic force_if
);

   localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;

   // Saturating count of denied fetch cycles; any grant or dropped request clears it.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wait_cnt <= '0;
      end else if (run && if_req && !if_gnt) begin
         wait_cnt <= sat_inc(wait_cnt, WAIT_LIM);
      end else begin
         wait_cnt <= '0;
      end
   end

   assign force_if = (wait_cnt == WAIT_LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single RAM port shared by the boot loader, CPU fetch and CPU load/store.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  BOOT   | loader owns the port, CPU stalled, no grants
//  SETTLE | one quiet cycle after boot_done, no writes, no grants
//  RUN    | CPU released; data wins over fetch except when fetch starved
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = RAM_ADDR_W,
   parameter int DATA_W   = RAM_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              Clk,
   input  logic              Reset,

   input  logic              boot_wren,
   input  logic [ADDR_W-1:0] boot_addr,
   input  logic [DATA_W-1:0] boot_data,
   input  logic              boot_done,

   mem_port_arbiter_if.slave cpu,

   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_q,

   output logic              cpu_run
);

   localparam logic [1:0] ST_BOOT   = BOOT;
   localparam logic [1:0] ST_SETTLE = SETTLE;
   localparam logic [1:0] ST_RUN    = RUN;

   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       run;
   logic       force_if;
   logic       if_win;
   logic       dm_win;
   logic       if_tag_q;
   logic       dm_tag_q;

   // Next-state: BOOT waits for the loader, SETTLE is a single cycle, RUN is sticky.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT:   if (boot_done) state_d = ST_SETTLE;
         ST_SETTLE: state_d = ST_RUN;
         ST_RUN:    state_d = ST_RUN;
         default:   state_d = ST_BOOT;
      endcase
   end

   // State register; Reset returns to BOOT immediately.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state_q <= ST_BOOT;
      else       state_q <= state_d;
   end

   assign run     = (state_q == ST_RUN);
   assign cpu_run = run;

   fetch_starve_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .Clk      (Clk),
      .Reset    (Reset),
      .run      (run),
      .if_req   (cpu.if_req),
      .if_gnt   (if_win),
      .force_if (force_if)
   );

   // Same-cycle arbitration: data first, fetch when alone or starved.
   always_comb begin
      if_win = run && cpu.if_req && (!cpu.dm_req || force_if);
      dm_win = run && cpu.dm_req && !if_win;
   end

   assign cpu.if_gnt = if_win;
   assign cpu.dm_gnt = dm_win;

   // RAM port mux. Reset gates the loader strobe so the port is quiet while held.
   always_comb begin
      mem_addr  = cpu.if_addr;
      mem_wdata = cpu.dm_wdata;
      mem_wren  = 1'b0;
      case (state_q)
         ST_BOOT: begin
            mem_addr  = boot_addr;
            mem_wdata = boot_data;
            mem_wren  = boot_wren && !Reset;
         end
         ST_SETTLE: begin
            mem_addr  = boot_addr;
            mem_wdata = boot_data;
         end
         ST_RUN: begin
            mem_addr = dm_win ? cpu.dm_addr : cpu.if_addr;
            mem_wren = dm_win && cpu.dm_we;
         end
         default: ;
      endcase
   end

   // Read-return tags: mark which requester owns next cycle's mem_q. Stores leave no tag.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         if_tag_q <= 1'b0;
         dm_tag_q <= 1'b0;
      end else begin
         if_tag_q <= if_win;
         dm_tag_q <= dm_win && !cpu.dm_we;
      end
   end

   assign cpu.if_rvalid = if_tag_q;
   assign cpu.dm_rvalid = dm_tag_q;
   assign cpu.if_rdata  = mem_q;
   assign cpu.dm_rdata  = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: boot load, starvation pattern, directed reads and
// stores, randomized RUN traffic against a queue-free reference model, and reset
// in the middle of a load.
module tb_mem_port_arbiter;

   localparam int MAX_WAIT = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        boot_wren;
   logic [15:0] boot_addr;
   logic [31:0] boot_data;
   logic        boot_done;
   logic [15:0] mem_addr;
   logic        mem_wren;
   logic [31:0] mem_wdata;
   logic [31:0] mem_q;
   logic        cpu_run;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) cpu_bus ();

   mem_port_arbiter #(
      .ADDR_W   (16),
      .DATA_W   (32),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .boot_wren (boot_wren),
      .boot_addr (boot_addr),
      .boot_data (boot_data),
      .boot_done (boot_done),
      .cpu       (cpu_bus),
      .mem_addr  (mem_addr),
      .mem_wren  (mem_wren),
      .mem_wdata (mem_wdata),
      .mem_q     (mem_q),
      .cpu_run   (cpu_run)
   );

   always #5 Clk = ~Clk;

   // Synchronous-read RAM macro
   logic [31:0] ram [0:65535];
   always @(posedge Clk) begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      mem_q <= ram[mem_addr];
   end

   // Reference model state
   logic [31:0] model_mem [0:255];
   int          streak;
   logic        exp_if_rv, exp_dm_rv;
   logic [31:0] exp_rd;
   logic        last_if_gnt, last_dm_gnt;
   logic        act_if_gnt;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One non-RUN cycle: boot inputs driven, port must follow the loader (or stay quiet).
   task automatic boot_cyc(input logic wr, input logic [15:0] a, input logic [31:0] d,
                           input logic done, input logic exp_wren, input logic chk_addr);
      boot_wren = wr;
      boot_addr = a;
      boot_data = d;
      boot_done = done;
      @(negedge Clk);
      check("boot_mem_wren", mem_wren, exp_wren);
      check("boot_cpu_run", cpu_run, 1'b0);
      check("boot_if_gnt", cpu_bus.if_gnt, 1'b0);
      check("boot_dm_gnt", cpu_bus.dm_gnt, 1'b0);
      check("boot_if_rvalid", cpu_bus.if_rvalid, 1'b0);
      check("boot_dm_rvalid", cpu_bus.dm_rvalid, 1'b0);
      if (chk_addr) begin
         check("boot_mem_addr", mem_addr, a);
         check("boot_mem_wdata", mem_wdata, d);
      end
      @(posedge Clk);
      #1;
   endtask

   // One RUN cycle with the CPU inputs already driven.
   task automatic cyc();
      logic        e_if, e_dm, e_wren;
      logic [15:0] e_addr;
      @(negedge Clk);
      e_if   = cpu_bus.if_req && (!cpu_bus.dm_req || streak == MAX_WAIT);
      e_dm   = cpu_bus.dm_req && !e_if;
      e_addr = e_dm ? cpu_bus.dm_addr : cpu_bus.if_addr;
      e_wren = e_dm && cpu_bus.dm_we;
      check("run_cpu_run", cpu_run, 1'b1);
      check("if_gnt", cpu_bus.if_gnt, e_if);
      check("dm_gnt", cpu_bus.dm_gnt, e_dm);
      check("mem_wren", mem_wren, e_wren);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, cpu_bus.dm_wdata);
      check("if_rvalid", cpu_bus.if_rvalid, exp_if_rv);
      check("dm_rvalid", cpu_bus.dm_rvalid, exp_dm_rv);
      if (exp_if_rv) check("if_rdata", cpu_bus.if_rdata, exp_rd);
      if (exp_dm_rv) check("dm_rdata", cpu_bus.dm_rdata, exp_rd);
      act_if_gnt = cpu_bus.if_gnt;
      exp_if_rv  = e_if;
      exp_dm_rv  = e_dm && !cpu_bus.dm_we;
      if (e_if) exp_rd = model_mem[cpu_bus.if_addr[7:0]];
      else if (exp_dm_rv) exp_rd = model_mem[cpu_bus.dm_addr[7:0]];
      if (e_wren) model_mem[cpu_bus.dm_addr[7:0]] = cpu_bus.dm_wdata;
      if (cpu_bus.if_req && !e_if) streak = (streak + 1 > MAX_WAIT) ? MAX_WAIT : streak + 1;
      else streak = 0;
      last_if_gnt = e_if;
      last_dm_gnt = e_dm;
      @(posedge Clk);
      #1;
   endtask

   // Requesters move to a fresh load/fetch address once granted.
   task automatic next_addrs();
      if (last_if_gnt) cpu_bus.if_addr = 16'($urandom_range(0, 255));
      if (last_dm_gnt) cpu_bus.dm_addr = 16'($urandom_range(0, 255));
   endtask

   initial begin
      int          a;
      int          if_grants;
      logic        wr;
      logic [31:0] d;

      streak      = 0;
      exp_if_rv   = 1'b0;
      exp_dm_rv   = 1'b0;
      exp_rd      = '0;
      last_if_gnt = 1'b0;
      last_dm_gnt = 1'b0;
      act_if_gnt  = 1'b0;

      Reset     = 1'b1;
      boot_wren = 1'b1;
      boot_addr = 16'h0000;
      boot_data = 32'h0;
      boot_done = 1'b0;
      cpu_bus.if_req   = 1'b1;
      cpu_bus.if_addr  = 16'h0003;
      cpu_bus.dm_req   = 1'b1;
      cpu_bus.dm_we    = 1'b0;
      cpu_bus.dm_addr  = 16'h0005;
      cpu_bus.dm_wdata = 32'h0;

      #12;
      check("rst_cpu_run", cpu_run, 1'b0);
      check("rst_if_gnt", cpu_bus.if_gnt, 1'b0);
      check("rst_dm_gnt", cpu_bus.dm_gnt, 1'b0);
      check("rst_if_rvalid", cpu_bus.if_rvalid, 1'b0);
      check("rst_dm_rvalid", cpu_bus.dm_rvalid, 1'b0);
      check("rst_mem_wren", mem_wren, 1'b0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;

      // Boot load of 0..255 with idle gaps; CPU requests held high the whole time.
      a = 0;
      while (a < 256) begin
         wr = ($urandom_range(0, 3) != 0);
         d  = (a == 0) ? 32'h0000_0093 : $urandom;
         cpu_bus.if_addr = 16'($urandom_range(0, 255));
         boot_cyc(wr, 16'(a), d, wr && (a == 255), wr, 1'b1);
         if (wr) begin
            model_mem[a] = d;
            a++;
         end
      end

      // SETTLE: a loader strobe here must not reach the RAM.
      boot_cyc(1'b1, 16'h0077, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

      // RUN from the first cycle: both requests held, dm x4 then if, repeating.
      boot_done = 1'b0;
      cpu_bus.if_addr = 16'h0003;
      if_grants = 0;
      for (int i = 0; i < 15; i++) begin
         cyc();
         if (act_if_gnt) if_grants++;
         next_addrs();
      end
      check("starve_if_grants", 64'(if_grants), 64'(15 / (MAX_WAIT + 1)));

      // Dropping the fetch request resets the starvation count.
      for (int i = 0; i < 3; i++) begin
         cyc();
         next_addrs();
      end
      cpu_bus.if_req = 1'b0;
      cyc();
      next_addrs();
      cpu_bus.if_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         next_addrs();
      end

      cpu_bus.if_req = 1'b0;
      cpu_bus.dm_req = 1'b0;
      cyc();

      // Fetch of the boot-loaded word at address 0.
      cpu_bus.if_req  = 1'b1;
      cpu_bus.if_addr = 16'h0000;
      cyc();
      cpu_bus.if_req = 1'b0;
      cyc();

      // Store then load at 0x20.
      cpu_bus.dm_req   = 1'b1;
      cpu_bus.dm_we    = 1'b1;
      cpu_bus.dm_addr  = 16'h0020;
      cpu_bus.dm_wdata = 32'hDEAD_BEEF;
      cyc();
      cpu_bus.dm_we = 1'b0;
      cyc();
      cpu_bus.dm_req = 1'b0;
      cyc();

      // Randomized traffic; an ungranted request usually stays put.
      for (int i = 0; i < 400; i++) begin
         if (!(cpu_bus.if_req && !last_if_gnt && $urandom_range(0, 9) != 0)) begin
            cpu_bus.if_req  = 1'($urandom_range(0, 1));
            cpu_bus.if_addr = 16'($urandom_range(0, 255));
         end
         if (!(cpu_bus.dm_req && !last_dm_gnt && $urandom_range(0, 9) != 0)) begin
            cpu_bus.dm_req   = 1'($urandom_range(0, 1));
            cpu_bus.dm_we    = 1'($urandom_range(0, 1));
            cpu_bus.dm_addr  = 16'($urandom_range(0, 255));
            cpu_bus.dm_wdata = $urandom;
         end
         cyc();
      end
      cpu_bus.if_req = 1'b0;
      cpu_bus.dm_req = 1'b0;
      cyc();

      // Reset right after a load grant: no rvalid, CPU stalls at once, back in BOOT.
      cpu_bus.dm_req  = 1'b1;
      cpu_bus.dm_we   = 1'b0;
      cpu_bus.dm_addr = 16'h0010;
      cyc();
      boot_wren = 1'b0;
      boot_addr = 16'h0042;
      Reset     = 1'b1;
      #1;
      check("rstmid_cpu_run", cpu_run, 1'b0);
      check("rstmid_dm_rvalid_now", cpu_bus.dm_rvalid, 1'b0);
      @(negedge Clk);
      check("rstmid_dm_rvalid", cpu_bus.dm_rvalid, 1'b0);
      check("rstmid_dm_gnt", cpu_bus.dm_gnt, 1'b0);
      check("rstmid_mem_addr", mem_addr, 16'h0042);
      check("rstmid_mem_wren", mem_wren, 1'b0);
      @(posedge Clk);
      #1;
      Reset     = 1'b0;
      boot_wren = 1'b1;
      @(negedge Clk);
      check("reboot_cpu_run", cpu_run, 1'b0);
      check("reboot_mem_wren", mem_wren, 1'b1);
      check("reboot_mem_addr", mem_addr, 16'h0042);
      check("reboot_dm_gnt", cpu_bus.dm_gnt, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
